// File: rtl/trace_mem_writer.sv
// rtl/trace_mem_writer.sv - packs 512-bit trace beats into AXI4 INCR bursts written to a circular buffer
module trace_mem_writer #(
  parameter int ADDR_W    = 48,
  parameter int BURST_LEN = 16,
  parameter int ID_W      = 4
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              enable,
  input  logic [ADDR_W-1:0] buf_base,
  input  logic [31:0]       buf_size,
  output logic [31:0]       wr_ptr,
  output logic [31:0]       wrap_cnt,
  output logic              busy,
  output logic              err,
  input  logic              s_axis_trace_tvalid,
  output logic              s_axis_trace_tready,
  input  logic              s_axis_trace_tlast,
  input  logic [511:0]      s_axis_trace_tdata,
  input  logic [63:0]       s_axis_trace_tkeep,
  output logic [ID_W-1:0]   m_axi_awid,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic [7:0]        m_axi_awlen,
  output logic [2:0]        m_axi_awsize,
  output logic [1:0]        m_axi_awburst,
  output logic [3:0]        m_axi_awcache,
  output logic [2:0]        m_axi_awprot,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [511:0]      m_axi_wdata,
  output logic [63:0]       m_axi_wstrb,
  output logic              m_axi_wlast,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic [ID_W-1:0]   m_axi_bid,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready
);

  localparam int CW = $clog2(BURST_LEN + 1);
  localparam int IW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_ADDR, S_DATA, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     lim_q, lim_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [31:0]       wr_ptr_q, wr_ptr_d;
  logic [31:0]       wrap_cnt_q, wrap_cnt_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              tready_q, tready_d;
  logic              awvalid_q, awvalid_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [7:0]        awlen_q, awlen_d;
  logic              wvalid_q, wvalid_d;
  logic [511:0]      wdata_q, wdata_d;
  logic [63:0]       wstrb_q, wstrb_d;
  logic              wlast_q, wlast_d;
  logic              bready_q, bready_d;

  logic [511:0]      beat_data_mem [BURST_LEN];
  logic [63:0]       beat_keep_mem [BURST_LEN];

  logic              t_hs, aw_hs, w_hs, b_hs;
  logic [CW-1:0]     fill_cnt;
  logic [IW-1:0]     idx_nx;
  logic [31:0]       ptr_sum;
  logic              ptr_wrap;
  logic              unused_bid;

  assign t_hs     = s_axis_trace_tvalid & tready_q;
  assign aw_hs    = awvalid_q & m_axi_awready;
  assign w_hs     = wvalid_q & m_axi_wready;
  assign b_hs     = bready_q & m_axi_bvalid;
  assign fill_cnt = t_hs ? cnt_q + CW'(1) : cnt_q;
  assign idx_nx   = idx_q + IW'(1);
  assign ptr_sum  = wr_ptr_q + (32'(cnt_q) << 6);
  assign ptr_wrap = (ptr_sum == buf_size);
  assign unused_bid = ^m_axi_bid;

  // Burst may not run past the buffer end nor cross a 4 KB page.
  function automatic logic [CW-1:0] calc_lim(input logic [31:0] size, input logic [31:0] ptr);
    logic [31:0] rem_buf, rem_page, m;
    rem_buf  = (size - ptr) >> 6;
    rem_page = (32'd4096 - {20'd0, ptr[11:0]}) >> 6;
    m = 32'(BURST_LEN);
    if (rem_buf < m) m = rem_buf;
    if (rem_page < m) m = rem_page;
    return CW'(m);
  endfunction

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      lim_q      <= '0;
      idx_q      <= '0;
      wr_ptr_q   <= '0;
      wrap_cnt_q <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      tready_q   <= 1'b0;
      awvalid_q  <= 1'b0;
      awaddr_q   <= '0;
      awlen_q    <= '0;
      wvalid_q   <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      wlast_q    <= 1'b0;
      bready_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lim_q      <= lim_d;
      idx_q      <= idx_d;
      wr_ptr_q   <= wr_ptr_d;
      wrap_cnt_q <= wrap_cnt_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      tready_q   <= tready_d;
      awvalid_q  <= awvalid_d;
      awaddr_q   <= awaddr_d;
      awlen_q    <= awlen_d;
      wvalid_q   <= wvalid_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      wlast_q    <= wlast_d;
      bready_q   <= bready_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (t_hs) begin
      beat_data_mem[cnt_q[IW-1:0]] <= s_axis_trace_tdata;
      beat_keep_mem[cnt_q[IW-1:0]] <= s_axis_trace_tkeep;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (enable) state_d = S_FILL;
      S_FILL: begin
        if (fill_cnt == lim_q || (t_hs && s_axis_trace_tlast) || (!enable && fill_cnt != '0))
          state_d = S_ADDR;
        else if (!enable)
          state_d = S_IDLE;
      end
      S_ADDR: if (aw_hs) state_d = S_DATA;
      S_DATA: if (w_hs && wlast_q) state_d = S_RESP;
      S_RESP: if (b_hs) state_d = enable ? S_FILL : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    wr_ptr_d   = wr_ptr_q;
    wrap_cnt_d = wrap_cnt_q;
    err_d      = err_q;
    awvalid_d  = awvalid_q;
    awaddr_d   = awaddr_q;
    awlen_d    = awlen_q;
    wvalid_d   = wvalid_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    wlast_d    = wlast_q;
    bready_d   = bready_q;

    unique case (state_q)
      S_IDLE: begin
        if (enable) begin
          wr_ptr_d   = '0;
          wrap_cnt_d = '0;
        end
      end
      S_FILL: begin
        cnt_d = fill_cnt;
        if (state_d == S_ADDR) begin
          awvalid_d = 1'b1;
          awaddr_d  = buf_base + ADDR_W'(wr_ptr_q);
          awlen_d   = 8'(fill_cnt) - 8'd1;
        end
      end
      S_ADDR: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b1;
          idx_d     = '0;
          wdata_d   = beat_data_mem[0];
          wstrb_d   = beat_keep_mem[0];
          wlast_d   = (cnt_q == CW'(1));
        end
      end
      S_DATA: begin
        if (w_hs) begin
          if (wlast_q) begin
            wvalid_d = 1'b0;
            wlast_d  = 1'b0;
            bready_d = 1'b1;
          end else begin
            idx_d   = idx_nx;
            wdata_d = beat_data_mem[idx_nx];
            wstrb_d = beat_keep_mem[idx_nx];
            wlast_d = (32'(idx_nx) + 32'd1 == 32'(cnt_q));
          end
        end
      end
      S_RESP: begin
        if (b_hs) begin
          bready_d = 1'b0;
          err_d    = err_q | (m_axi_bresp != 2'b00);
          cnt_d    = '0;
          if (ptr_wrap) begin
            wr_ptr_d   = '0;
            wrap_cnt_d = wrap_cnt_q + 32'd1;
          end else begin
            wr_ptr_d = ptr_sum;
          end
        end
      end
      default: ;
    endcase
  end

  // The limit is latched on FILL entry from the pointer that FILL will start at.
  always_comb begin
    lim_d    = lim_q;
    if (state_d == S_FILL && state_q != S_FILL)
      lim_d = calc_lim(buf_size, wr_ptr_d);
    tready_d = (state_d == S_FILL) && (cnt_d < lim_d);
    busy_d   = (state_d != S_IDLE);
  end

  assign wr_ptr              = wr_ptr_q;
  assign wrap_cnt            = wrap_cnt_q;
  assign busy                = busy_q;
  assign err                 = err_q;
  assign s_axis_trace_tready = tready_q;
  assign m_axi_awid          = '0;
  assign m_axi_awaddr        = awaddr_q;
  assign m_axi_awlen         = awlen_q;
  assign m_axi_awsize        = 3'd6;
  assign m_axi_awburst       = 2'b01;
  assign m_axi_awcache       = 4'b0011;
  assign m_axi_awprot        = 3'b000;
  assign m_axi_awvalid       = awvalid_q;
  assign m_axi_wdata         = wdata_q;
  assign m_axi_wstrb         = wstrb_q;
  assign m_axi_wlast         = wlast_q;
  assign m_axi_wvalid        = wvalid_q;
  assign m_axi_bready        = bready_q;

endmodule

// File: tb/tb_trace_mem_writer.sv
// tb/tb_trace_mem_writer.sv - randomized bench for trace_mem_writer against a burst-grouping reference model
module tb_trace_mem_writer;
  localparam int BL = 16;

  typedef struct {
    logic [511:0] d;
    logic [63:0]  k;
    logic         l;
  } beat_t;

  logic         aclk = 1'b0;
  logic         aresetn = 1'b1;
  logic         enable = 1'b0;
  logic [47:0]  buf_base = '0;
  logic [31:0]  buf_size = 32'd64;
  logic [31:0]  wr_ptr, wrap_cnt;
  logic         busy, err;
  logic         s_axis_trace_tvalid = 1'b0;
  logic         s_axis_trace_tready;
  logic         s_axis_trace_tlast = 1'b0;
  logic [511:0] s_axis_trace_tdata = '0;
  logic [63:0]  s_axis_trace_tkeep = '0;
  logic [3:0]   m_axi_awid;
  logic [47:0]  m_axi_awaddr;
  logic [7:0]   m_axi_awlen;
  logic [2:0]   m_axi_awsize;
  logic [1:0]   m_axi_awburst;
  logic [3:0]   m_axi_awcache;
  logic [2:0]   m_axi_awprot;
  logic         m_axi_awvalid;
  logic         m_axi_awready = 1'b0;
  logic [511:0] m_axi_wdata;
  logic [63:0]  m_axi_wstrb;
  logic         m_axi_wlast, m_axi_wvalid;
  logic         m_axi_wready = 1'b0;
  logic [3:0]   m_axi_bid = '0;
  logic [1:0]   m_axi_bresp = '0;
  logic         m_axi_bvalid = 1'b0;
  logic         m_axi_bready;

  int n_chk = 0;
  int n_pass = 0;

  beat_t       in_q[$];
  int          e_off[$], e_len[$], e_lim[$], e_start[$];
  logic [31:0] m_ptr, m_wrap;
  logic        m_err = 1'b0;

  trace_mem_writer #(.ADDR_W(48), .BURST_LEN(BL), .ID_W(4)) dut (
    .aclk(aclk), .aresetn(aresetn), .enable(enable),
    .buf_base(buf_base), .buf_size(buf_size),
    .wr_ptr(wr_ptr), .wrap_cnt(wrap_cnt), .busy(busy), .err(err),
    .s_axis_trace_tvalid(s_axis_trace_tvalid), .s_axis_trace_tready(s_axis_trace_tready),
    .s_axis_trace_tlast(s_axis_trace_tlast), .s_axis_trace_tdata(s_axis_trace_tdata),
    .s_axis_trace_tkeep(s_axis_trace_tkeep),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awcache(m_axi_awcache),
    .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Group the input beats into bursts from the buffer rules: page/end/BURST_LEN limit, tlast, stream end.
  task automatic model_bursts(input logic [31:0] size);
    int i, k, lim;
    logic [31:0] ptr;
    bit last;
    e_off.delete(); e_len.delete(); e_lim.delete(); e_start.delete();
    ptr = 0; m_wrap = 0; i = 0;
    while (i < in_q.size()) begin
      lim = BL;
      if ((size - ptr) / 64 < lim) lim = (size - ptr) / 64;
      if ((4096 - ptr % 4096) / 64 < lim) lim = (4096 - ptr % 4096) / 64;
      e_start.push_back(i);
      k = 0;
      do begin
        last = in_q[i].l;
        i++; k++;
      end while (k < lim && !last && i < in_q.size());
      e_off.push_back(ptr); e_len.push_back(k); e_lim.push_back(lim);
      ptr = ptr + k * 64;
      if (ptr == size) begin ptr = 0; m_wrap++; end
    end
    m_ptr = ptr;
  endtask

  task automatic run_scn(input string nm, input logic [47:0] base, input logic [31:0] size,
                         input int nbeats, input int n_single, input bit last_end, input int p_last,
                         input bit stall, input int err_burst, input bit reset_mid,
                         input bit use_const, input logic [31:0] c_ptr, input logic [31:0] c_wrap);
    beat_t b;
    int sidx = 0, aw_n = 0, w_n = 0, nb = 0, beat_k = 0, cyc = 0;
    int viol_cap = 0, viol_ovl = 0, viol_stb = 0;
    bit last_hs = 0, last_b = 0, b_pend = 0, aborted = 0, done = 0;
    bit aw_stall = 0, w_stall = 0;
    logic [47:0]  p_awaddr;
    logic [7:0]   p_awlen;
    logic [511:0] p_wdata;
    logic [63:0]  p_wstrb;
    logic         p_wlast;

    in_q.delete();
    for (int i = 0; i < nbeats; i++) begin
      for (int j = 0; j < 16; j++) b.d[j*32 +: 32] = $urandom;
      b.k = {$urandom, $urandom};
      b.l = (i < n_single) || (last_end && i == nbeats - 1) ||
            (p_last > 0 && $urandom_range(p_last - 1, 0) == 0);
      in_q.push_back(b);
    end
    model_bursts(size);
    if (err_burst >= 0 && err_burst < e_off.size()) m_err = 1'b1;

    buf_base = base;
    buf_size = size;
    @(negedge aclk);
    enable = 1'b1;
    @(negedge aclk);
    check({nm, ".ptr_clr"}, wr_ptr, 0);
    check({nm, ".busy_on"}, busy, 1);

    while (!done && cyc < 6000) begin
      @(negedge aclk);
      cyc++;
      if (aw_stall && (!m_axi_awvalid || m_axi_awaddr !== p_awaddr || m_axi_awlen !== p_awlen)) viol_stb++;
      if (w_stall && (!m_axi_wvalid || m_axi_wdata !== p_wdata || m_axi_wstrb !== p_wstrb ||
                      m_axi_wlast !== p_wlast)) viol_stb++;
      if (m_axi_awvalid && m_axi_wvalid) viol_ovl++;

      if (reset_mid && m_axi_wvalid && w_n >= 2) begin
        #2 aresetn = 1'b0;
        enable = 1'b0; s_axis_trace_tvalid = 1'b0; m_axi_bvalid = 1'b0;
        #1;
        check({nm, ".rst_awvalid"}, m_axi_awvalid, 0);
        check({nm, ".rst_wvalid"}, m_axi_wvalid, 0);
        check({nm, ".rst_bready"}, m_axi_bready, 0);
        check({nm, ".rst_tready"}, s_axis_trace_tready, 0);
        check({nm, ".rst_busy"}, busy, 0);
        check({nm, ".rst_err"}, err, 0);
        check({nm, ".rst_ptr"}, wr_ptr, 0);
        @(negedge aclk);
        aresetn = 1'b1;
        m_err = 1'b0;
        aborted = 1;
        break;
      end

      if (last_hs) s_axis_trace_tvalid = 1'b0;
      last_hs = 0;
      if (sidx < in_q.size() && !s_axis_trace_tvalid) begin
        s_axis_trace_tvalid = stall ? ($urandom_range(3, 0) != 0) : 1'b1;
        s_axis_trace_tdata  = in_q[sidx].d;
        s_axis_trace_tkeep  = in_q[sidx].k;
        s_axis_trace_tlast  = in_q[sidx].l;
      end
      if (s_axis_trace_tready && nb < e_len.size() && (sidx - e_start[nb]) >= e_lim[nb]) viol_cap++;
      if (s_axis_trace_tvalid && s_axis_trace_tready) begin
        sidx++;
        last_hs = 1;
      end
      if (sidx == in_q.size()) enable = 1'b0;

      m_axi_awready = stall ? 1'($urandom_range(1, 0)) : 1'b1;
      aw_stall = m_axi_awvalid && !m_axi_awready;
      p_awaddr = m_axi_awaddr; p_awlen = m_axi_awlen;
      if (m_axi_awvalid && m_axi_awready) begin
        if (aw_n < e_off.size()) begin
          check({nm, ".awaddr"}, m_axi_awaddr, base + 48'(e_off[aw_n]));
          check({nm, ".awlen"}, m_axi_awlen, e_len[aw_n] - 1);
          if (aw_n == 0)
            check({nm, ".aw_const"}, {m_axi_awsize, m_axi_awburst, m_axi_awcache, m_axi_awprot},
                  {3'd6, 2'd1, 4'b0011, 3'd0});
        end else begin
          check({nm, ".extra_aw"}, aw_n, e_off.size() - 1);
        end
        aw_n++;
        beat_k = 0;
      end

      if (last_b) m_axi_bvalid = 1'b0;
      last_b = 0;
      if (b_pend && !m_axi_bvalid) begin
        m_axi_bvalid = stall ? 1'($urandom_range(1, 0)) : 1'b1;
        m_axi_bresp  = (nb == err_burst) ? 2'b10 : 2'b00;
      end
      if (m_axi_bvalid && m_axi_bready) begin
        nb++;
        b_pend = 0;
        last_b = 1;
      end

      m_axi_wready = stall ? ($urandom_range(2, 0) != 0) : 1'b1;
      w_stall = m_axi_wvalid && !m_axi_wready;
      p_wdata = m_axi_wdata; p_wstrb = m_axi_wstrb; p_wlast = m_axi_wlast;
      if (m_axi_wvalid && m_axi_wready) begin
        if (w_n < in_q.size() && aw_n > 0 && aw_n <= e_len.size()) begin
          check({nm, ".wdata"}, m_axi_wdata, in_q[w_n].d);
          check({nm, ".wstrb"}, m_axi_wstrb, in_q[w_n].k);
          check({nm, ".wlast"}, m_axi_wlast, beat_k == e_len[aw_n - 1] - 1);
        end else begin
          check({nm, ".extra_w"}, w_n, in_q.size() - 1);
        end
        w_n++;
        beat_k++;
        if (m_axi_wlast) b_pend = 1;
      end

      done = (sidx == in_q.size()) && !b_pend && !enable && !busy;
    end

    s_axis_trace_tvalid = 1'b0;
    m_axi_bvalid = 1'b0;
    enable = 1'b0;
    if (!aborted) begin
      check({nm, ".timeout"}, done, 1);
      check({nm, ".n_bursts"}, aw_n, e_off.size());
      check({nm, ".n_beats"}, w_n, in_q.size());
      check({nm, ".wr_ptr"}, wr_ptr, m_ptr);
      check({nm, ".wrap_cnt"}, wrap_cnt, m_wrap);
      check({nm, ".err"}, err, m_err);
      check({nm, ".tready_cap"}, viol_cap, 0);
      check({nm, ".aw_w_overlap"}, viol_ovl, 0);
      check({nm, ".stable"}, viol_stb, 0);
      if (use_const) begin
        check({nm, ".wr_ptr_plan"}, wr_ptr, c_ptr);
        check({nm, ".wrap_plan"}, wrap_cnt, c_wrap);
      end
    end
  endtask

  initial begin
    #1 aresetn = 1'b0;
    #1;
    check("reset.awvalid", m_axi_awvalid, 0);
    check("reset.wvalid", m_axi_wvalid, 0);
    check("reset.bready", m_axi_bready, 0);
    check("reset.tready", s_axis_trace_tready, 0);
    check("reset.busy", busy, 0);
    check("reset.err", err, 0);
    check("reset.wr_ptr", wr_ptr, 0);
    check("reset.wrap_cnt", wrap_cnt, 0);
    check("reset.payload", {m_axi_awaddr, m_axi_awlen, m_axi_wstrb, m_axi_wlast}, 0);
    check("reset.wdata", m_axi_wdata, 0);
    @(negedge aclk);
    aresetn = 1'b1;

    run_scn("s1", 48'h1000_0000, 32'h1000, 32, 0, 0, 0, 0, -1, 0, 1, 32'h800, 0);
    run_scn("s2", 48'h1000_0000, 32'h1000, 3, 0, 1, 0, 0, -1, 0, 1, 32'hC0, 0);
    run_scn("s3", 48'h2000_0000, 32'h100, 10, 0, 0, 0, 0, -1, 0, 1, 32'h80, 2);
    run_scn("s4", 48'h3000_0000, 32'h2000, 79, 63, 0, 0, 0, -1, 0, 1, 32'h13C0, 0);
    run_scn("s5", 48'($urandom_range(4095, 1)) << 12, 32'(64 * $urandom_range(80, 4)),
            60, 0, 0, 6, 1, 1, 0, 0, 0, 0);
    run_scn("s6", 48'($urandom_range(4095, 1)) << 12, 32'(64 * $urandom_range(80, 4)),
            50, 0, 0, 5, 1, -1, 0, 0, 0, 0);
    run_scn("s7", 48'h4000_0000, 32'h1000, 40, 0, 0, 0, 1, -1, 1, 0, 0, 0);
    run_scn("s8", 48'($urandom_range(4095, 1)) << 12, 32'(64 * $urandom_range(80, 4)),
            45, 0, 0, 7, 1, -1, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
